// File: rtl/commit_store_buffer.sv
// Commit-side store buffer: holds executed stores in order, commits on Commit fires, drains to D-cache.
// Optional store-to-load forwarding is enabled by defining SB_LOAD_FWD_EN.
module commit_store_buffer #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        enq_valid,
    input  logic [31:0] enq_addr,
    input  logic [31:0] enq_data,
    input  logic [1:0]  enq_size,
    output logic        enq_ready,
    input  logic        fire0,
    input  logic        fire1,
    output logic        dc_req,
    output logic [31:0] dc_addr,
    output logic [31:0] dc_wdata,
    output logic [3:0]  dc_wstrb,
    input  logic        dc_ack,
    output logic        committed_pending,
    input  logic [31:0] ld_addr,
    output logic        ld_hit,
    output logic [31:0] ld_data,
    output logic [3:0]  ld_strb
);

    typedef enum logic {ST_IDLE, ST_REQ} state_t;

    localparam logic [PTR_W:0] DEPTH_P = (PTR_W+1)'(DEPTH);

    logic [PTR_W:0] r_head, r_cmt, r_tail;
    logic [29:0]    r_addr [DEPTH];
    logic [31:0]    r_data [DEPTH];
    logic [3:0]     r_strb [DEPTH];
    logic           r_committed_pending;
    state_t         r_state, w_state_next;

    logic [PTR_W:0] w_count, w_uncommitted, w_fire_cnt, w_cmt_step;
    logic [PTR_W:0] w_head_next, w_cmt_next, w_tail_next;
    logic           w_full, w_enq, w_deq;
    logic [3:0]     w_enq_strb;
    logic [31:0]    w_enq_data;
    logic [PTR_W-1:0] w_head_idx;

    assign w_count    = r_tail - r_head;
    assign w_full     = (w_count == DEPTH_P);
    assign enq_ready  = !w_full;
    assign w_enq      = enq_valid && !w_full && !flush;
    assign w_deq      = (r_state == ST_REQ) && dc_ack;
    assign w_head_idx = r_head[PTR_W-1:0];

    // Commit can never run past the youngest enqueued store, so excess fires are clamped.
    assign w_fire_cnt    = {{PTR_W{1'b0}}, fire0} + {{PTR_W{1'b0}}, fire1};
    assign w_uncommitted = r_tail - r_cmt;
    assign w_cmt_step    = (w_fire_cnt > w_uncommitted) ? w_uncommitted : w_fire_cnt;

    assign w_head_next = r_head + {{PTR_W{1'b0}}, w_deq};
    assign w_cmt_next  = r_cmt + w_cmt_step;
    assign w_tail_next = flush ? w_cmt_next : (r_tail + {{PTR_W{1'b0}}, w_enq});

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_enq_strb = 4'b1111;
        w_enq_data = enq_data;
        case (enq_size)
            2'd0: begin
                w_enq_strb = 4'b0001 << enq_addr[1:0];
                w_enq_data = {4{enq_data[7:0]}};
            end
            2'd1: begin
                w_enq_strb = enq_addr[1] ? 4'b1100 : 4'b0011;
                w_enq_data = {2{enq_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head              <= '0;
            r_cmt               <= '0;
            r_tail              <= '0;
            r_committed_pending <= 1'b0;
        end else begin
            r_head              <= w_head_next;
            r_cmt               <= w_cmt_next;
            r_tail              <= w_tail_next;
            r_committed_pending <= (w_head_next != w_cmt_next);
        end
    end

    // NOTE: entry storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_tail[PTR_W-1:0]] <= enq_addr[31:2];
            r_data[r_tail[PTR_W-1:0]] <= w_enq_data;
            r_strb[r_tail[PTR_W-1:0]] <= w_enq_strb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        dc_req       = 1'b0;
        case (r_state)
            ST_IDLE: if (r_head != r_cmt) w_state_next = ST_REQ;
            ST_REQ: begin
                dc_req = 1'b1;
                if (dc_ack && (w_head_next == w_cmt_next)) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Head entry is committed and cannot be overwritten, so these hold stable until dc_ack.
    assign dc_addr           = {r_addr[w_head_idx], 2'b00};
    assign dc_wdata          = r_data[w_head_idx];
    assign dc_wstrb          = r_strb[w_head_idx];
    assign committed_pending = r_committed_pending;

`ifdef SB_LOAD_FWD_EN
    logic [PTR_W:0] w_slot;
    logic           w_unused_ld_lsb;
    assign w_unused_ld_lsb = ^ld_addr[1:0];

    // Scan oldest to youngest so the youngest matching store overrides older ones.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        ld_strb = '0;
        w_slot  = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_slot = r_head + (PTR_W+1)'(i);
            if (((PTR_W+1)'(i) < w_count) && (r_addr[w_slot[PTR_W-1:0]] == ld_addr[31:2])) begin
                ld_hit  = 1'b1;
                ld_data = r_data[w_slot[PTR_W-1:0]];
                ld_strb = r_strb[w_slot[PTR_W-1:0]];
            end
        end
    end
`else
    logic w_unused_ld;
    assign w_unused_ld = ^ld_addr;
    assign ld_hit      = 1'b0;
    assign ld_data     = '0;
    assign ld_strb     = '0;
`endif

    a_cmt_within_queue: assert property (@(posedge clk) disable iff (rst)
        (r_cmt - r_head) <= (r_tail - r_head));

endmodule
